// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared constants for the multiplexed seven-segment display driver.
//   SEG_0 .. SEG_F : active-high {g,f,e,d,c,b,a} patterns for hex digits 0-F
//   SEG_OFF        : active-high "all segments off" pattern
//   seg_blank()    : the "all off" segment value after polarity is applied
// -----------------------------------------------------------------------------
package disp_pkg;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Value that turns every segment off once the pin polarity is applied.
  function automatic logic [6:0] seg_blank(input logic active_low);
    return active_low ? ~SEG_OFF : SEG_OFF;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// -----------------------------------------------------------------------------
// hex_to_7seg
// Purely combinational hex nibble to seven-segment decoder.
//   hex_i : 4-bit hex value
//   seg_o : active-high segment pattern {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module hex_to_7seg
  import disp_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    unique case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/mux_display_scanner.sv
// -----------------------------------------------------------------------------
// mux_display_scanner
// Time-multiplexed seven-segment display driver for NUM_DIGITS digits.
// A prescaler produces a tick every TICK_DIV clks; each digit slot lasts
// 2**BRIGHT_W ticks, and the digit is lit for the first bright_q+1 ticks.
// Display data is snapshotted once per frame so a frame never tears.
//   clk          : system clock
//   reset        : asynchronous, active-low
//   digits_i     : hex nibble per digit, nibble 0 = least significant digit
//   dp_i         : decimal point request per digit
//   blank_lz_i   : 1 = blank leading zeros (digit 0 always shown)
//   brightness_i : on-time code, sampled at each slot start
//   enable_i     : 0 = all digits dark, scanning continues
//   sel_o        : index of the digit currently driven
//   cat_o        : one-hot digit enable (polarity per CAT_ACTIVE_LOW)
//   seg_o        : segments {g,f,e,d,c,b,a} (polarity per SEG_ACTIVE_LOW)
//   dp_o         : decimal point segment (polarity per SEG_ACTIVE_LOW)
//   frame_o      : one-clk pulse when sel_o wraps back to digit 0
// -----------------------------------------------------------------------------
module mux_display_scanner
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int TICK_DIV       = 50000,
  parameter int BRIGHT_W       = 4,
  parameter int CAT_ACTIVE_LOW = 0,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       digits_i,
  input  logic [NUM_DIGITS-1:0]         dp_i,
  input  logic                          blank_lz_i,
  input  logic [BRIGHT_W-1:0]           brightness_i,
  input  logic                          enable_i,
  output logic [$clog2(NUM_DIGITS)-1:0] sel_o,
  output logic [NUM_DIGITS-1:0]         cat_o,
  output logic [6:0]                    seg_o,
  output logic                          dp_o,
  output logic                          frame_o
);

  localparam int SEL_W   = $clog2(NUM_DIGITS);
  localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [SEL_W-1:0]      IDX_LAST   = SEL_W'(NUM_DIGITS - 1);
  localparam logic                  SEG_INV    = (SEG_ACTIVE_LOW != 0);
  localparam logic                  CAT_INV    = (CAT_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] CAT_OFF    = {NUM_DIGITS{CAT_INV}};

  // Scan state
  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic [BRIGHT_W-1:0]     tcnt_q, tcnt_d;
  logic [SEL_W-1:0]        idx_q, idx_d;
  logic [BRIGHT_W-1:0]     bright_q, bright_d;
  logic                    first_q, first_d;

  // Frame snapshot
  logic [4*NUM_DIGITS-1:0] snap_dig_q, snap_dig_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                    snap_blz_q, snap_blz_d;

  // Output registers
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [NUM_DIGITS-1:0]   cat_q, cat_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_q, frame_d;

  // Combinational helpers
  logic                    tick, slot_end, slot_start, wrap;
  logic [SEL_W-1:0]        idx_safe;
  logic [NUM_DIGITS-1:0]   onehot, blank_vec;
  logic                    upper_zero, blanked, dp_sel, digit_on;
  logic [3:0]              nib;
  logic [6:0]              seg_raw;

  hex_to_7seg u_dec (
    .hex_i (nib),
    .seg_o (seg_raw)
  );

  // Counters, snapshot and brightness sampling
  always_comb begin
    tick       = (presc_q == PRESC_LAST);
    slot_end   = tick && (tcnt_q == {BRIGHT_W{1'b1}});
    slot_start = (presc_q == '0) && (tcnt_q == '0);
    // An out-of-range index (non-power-of-2 digit count) is treated as 0.
    idx_safe   = (idx_q > IDX_LAST) ? '0 : idx_q;
    wrap       = slot_end && (idx_safe == IDX_LAST);

    presc_d  = tick ? '0 : presc_q + 1'b1;
    tcnt_d   = tick ? tcnt_q + 1'b1 : tcnt_q;
    idx_d    = idx_safe;
    if (slot_end) begin
      idx_d = wrap ? '0 : idx_safe + 1'b1;
    end
    bright_d = slot_start ? brightness_i : bright_q;
    first_d  = 1'b0;

    snap_dig_d = snap_dig_q;
    snap_dp_d  = snap_dp_q;
    snap_blz_d = snap_blz_q;
    if (first_q || wrap) begin
      snap_dig_d = digits_i;
      snap_dp_d  = dp_i;
      snap_blz_d = blank_lz_i;
    end
  end

  // Digit selection, leading-zero blanking and output values
  always_comb begin
    onehot     = '0;
    blank_vec  = '0;
    upper_zero = 1'b1;
    nib        = 4'h0;
    dp_sel     = 1'b0;
    blanked    = 1'b0;

    // Walk from the most significant digit down: a digit is a leading zero
    // when it and every digit above it are zero.
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero   = upper_zero && (snap_dig_q[4*k +: 4] == 4'h0);
      blank_vec[k] = snap_blz_q && upper_zero && (k != 0);
    end

    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (SEL_W'(k) == idx_safe) begin
        onehot[k] = 1'b1;
        nib       = snap_dig_q[4*k +: 4];
        dp_sel    = snap_dp_q[k];
        blanked   = blank_vec[k];
      end
    end

    digit_on = enable_i && (tcnt_q <= bright_q) && !blanked;

    cat_d = CAT_OFF;
    seg_d = seg_blank(SEG_INV);
    dp_d  = SEG_INV;
    if (digit_on) begin
      cat_d = onehot ^ CAT_OFF;
      seg_d = seg_raw ^ {7{SEG_INV}};
      dp_d  = dp_sel ^ SEG_INV;
    end

    sel_d   = idx_safe;
    frame_d = (idx_safe == '0) && (sel_q == IDX_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q    <= '0;
      tcnt_q     <= '0;
      idx_q      <= '0;
      bright_q   <= '0;
      first_q    <= 1'b1;
      snap_dig_q <= '0;
      snap_dp_q  <= '0;
      snap_blz_q <= 1'b0;
      sel_q      <= '0;
      cat_q      <= CAT_OFF;
      seg_q      <= seg_blank(SEG_INV);
      dp_q       <= SEG_INV;
      frame_q    <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      tcnt_q     <= tcnt_d;
      idx_q      <= idx_d;
      bright_q   <= bright_d;
      first_q    <= first_d;
      snap_dig_q <= snap_dig_d;
      snap_dp_q  <= snap_dp_d;
      snap_blz_q <= snap_blz_d;
      sel_q      <= sel_d;
      cat_q      <= cat_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      frame_q    <= frame_d;
    end
  end

  assign sel_o   = sel_q;
  assign cat_o   = cat_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_mux_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_mux_display_scanner
// Directed bench for mux_display_scanner with NUM_DIGITS=4, TICK_DIV=2,
// BRIGHT_W=2: one slot is 8 clks, one frame is 32 clks. cyc counts rising
// edges since reset release; the outputs seen after edge cyc belong to slot
// ((cyc-1)/8)%4, and frame_o pulses at cyc = 33, 65, ...
// -----------------------------------------------------------------------------
module tb_mux_display_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits_i;
  logic [3:0]  dp_i;
  logic        blank_lz_i;
  logic [1:0]  brightness_i;
  logic        enable_i;
  logic [1:0]  sel_o;
  logic [3:0]  cat_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        frame_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  mux_display_scanner #(
    .NUM_DIGITS     (4),
    .TICK_DIV       (2),
    .BRIGHT_W       (2),
    .CAT_ACTIVE_LOW (0),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .digits_i     (digits_i),
    .dp_i         (dp_i),
    .blank_lz_i   (blank_lz_i),
    .brightness_i (brightness_i),
    .enable_i     (enable_i),
    .sel_o        (sel_o),
    .cat_o        (cat_o),
    .seg_o        (seg_o),
    .dp_o         (dp_o),
    .frame_o      (frame_o)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance n clks, checking the scan position and frame pulse each clk.
  task automatic tick_sel(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_val("sel", 32'(sel_o), 32'(((cyc - 1) / 8) % 4));
      check_val("frame", 32'(frame_o), 32'((cyc > 1) && (cyc % 32 == 1)));
    end
  endtask

  // cats: expected active-high cat per slot (4 bits each, slot 0 lowest)
  // pats: active-high segment pattern per slot (7 bits each)
  // dps : decimal point request per slot
  task automatic run_check(input int n, input logic [15:0] cats,
                           input logic [27:0] pats, input logic [3:0] dps);
    int         s;
    logic [3:0] ecat;
    logic [6:0] eseg;
    logic       edp;
    for (int i = 0; i < n; i++) begin
      tick_sel(1);
      s    = ((cyc - 1) / 8) % 4;
      ecat = cats[s*4 +: 4];
      eseg = (ecat != 4'h0) ? ~pats[s*7 +: 7] : 7'h7F;
      edp  = ((ecat != 4'h0) && dps[s]) ? 1'b0 : 1'b1;
      check_val("cat", 32'(cat_o), 32'(ecat));
      check_val("seg", 32'(seg_o), 32'(eseg));
      check_val("dp", 32'(dp_o), 32'(edp));
    end
  endtask

  task automatic count_on(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      tick_sel(1);
      if (cat_o != 4'h0) c++;
    end
  endtask

  int on_a, on_b;

  initial begin
    reset        = 1'b0;
    digits_i     = 16'h12AF;
    dp_i         = 4'b0100;
    blank_lz_i   = 1'b0;
    brightness_i = 2'd3;
    enable_i     = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_cat", 32'(cat_o), 32'h0);
    check_val("rst_seg", 32'(seg_o), 32'h7F);
    check_val("rst_sel", 32'(sel_o), 32'h0);
    check_val("rst_frame", 32'(frame_o), 32'h0);
    check_val("rst_dp", 32'(dp_o), 32'h1);

    @(negedge clk);
    reset = 1'b1;
    cyc   = 0;

    // First slot shows the reset-time snapshot for one clk; check scan only.
    tick_sel(8);
    // 12AF: digit0 F, digit1 A, digit2 2 with dp, digit3 1
    run_check(32, 16'h8421, {7'h06, 7'h5B, 7'h77, 7'h71}, 4'b0100);

    // Brightness 0: 2 clks on per slot; change to 2 mid-slot.
    brightness_i = 2'd0;
    count_on(8, on_a);
    check_val("bright0_on", 32'(on_a), 32'd2);
    count_on(4, on_a);
    brightness_i = 2'd2;
    count_on(4, on_b);
    check_val("bright_mid_on", 32'(on_a + on_b), 32'd2);
    count_on(8, on_a);
    check_val("bright2_on", 32'(on_a), 32'd6);

    // Leading-zero blanking; the new data waits for the next frame wrap.
    brightness_i = 2'd3;
    digits_i     = 16'h0050;
    dp_i         = 4'b0000;
    blank_lz_i   = 1'b1;
    tick_sel(32);
    run_check(32, 16'h0021, {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b0000);
    digits_i = 16'h0000;
    tick_sel(32);
    run_check(32, 16'h0001, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000);

    // Mid-frame data change must not tear the frame.
    digits_i   = 16'h1111;
    blank_lz_i = 1'b0;
    tick_sel(32);
    run_check(12, 16'h8421, {7'h06, 7'h06, 7'h06, 7'h06}, 4'b0000);
    digits_i = 16'h2222;
    run_check(20, 16'h8421, {7'h06, 7'h06, 7'h06, 7'h06}, 4'b0000);
    run_check(32, 16'h8421, {7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b0000);

    // Disable for 20 clks: dark, but scanning continues.
    tick_sel(2);
    enable_i = 1'b0;
    run_check(20, 16'h0000, {7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b0000);
    enable_i = 1'b1;
    run_check(30, 16'h8421, {7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b0000);

    // Now mid-slot on digit 2; assert reset between clock edges.
    check_val("pre_rst_sel", 32'(sel_o), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check_val("async_cat", 32'(cat_o), 32'h0);
    check_val("async_seg", 32'(seg_o), 32'h7F);
    check_val("async_sel", 32'(sel_o), 32'h0);
    check_val("async_dp", 32'(dp_o), 32'h1);
    check_val("async_frame", 32'(frame_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
